// File: rtl/facs_pkg.sv
// Shared constants and the single-bit add/subtract cell function for facs.
package facs_pkg;

  localparam logic FACS_MODE_ADD = 1'b0;
  localparam logic FACS_MODE_SUB = 1'b1;

  typedef struct packed {
    logic s;
    logic co;
  } facs_bit_t;

  // One full-adder cell; y is inverted when subtracting.
  function automatic facs_bit_t facs_bit_f(input logic mode, input logic x,
                                           input logic y, input logic c);
    facs_bit_t r;
    logic      yi;
    yi   = y ^ (mode == FACS_MODE_SUB);
    r.s  = x ^ yi ^ c;
    r.co = (x & yi) | (c & (x ^ yi));
    return r;
  endfunction

endpackage

// File: rtl/facs_bit.sv
// Combinational single-bit add/subtract cell.
module facs_bit
  import facs_pkg::*;
(
  input  logic mode,
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);

  facs_bit_t r_c;

  always_comb r_c = facs_bit_f(mode, x, y, c);

  assign s  = r_c.s;
  assign co = r_c.co;

endmodule

// File: rtl/facs.sv
// Registered ripple adder/subtractor built from WIDTH facs_bit cells.
// Optional signed-overflow output ovf when FACS_OVERFLOW_EN is defined.
module facs
  import facs_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef FACS_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  logic [WIDTH-1:0] s_c;
  logic [WIDTH:0]   c_c;

  assign c_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    facs_bit u_bit (
      .mode (mode),
      .x    (x[i]),
      .y    (y[i]),
      .c    (c_c[i]),
      .s    (s_c[i]),
      .co   (c_c[i+1])
    );
  end

  // Result only loads on valid input, so idle-cycle operands never reach the outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
`ifdef FACS_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s_c;
        cout <= c_c[WIDTH];
`ifdef FACS_OVERFLOW_EN
        ovf  <= c_c[WIDTH] ^ c_c[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_facs.sv
// Self-checking bench for facs at WIDTH=1 and WIDTH=8 driven from shared stimulus.
module tb_facs;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mode;
  logic [7:0] x8;
  logic [7:0] y8;
  logic       cin;
  logic       in_valid;

  logic       d1_sum, d1_cout, d1_ov;
  logic [7:0] d8_sum;
  logic       d8_cout, d8_ov;
`ifdef FACS_OVERFLOW_EN
  logic       d1_ovf, d8_ovf;
  logic       m1_ovf, m8_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  facs #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .x(x8[0]), .y(y8[0]), .cin(cin),
    .in_valid(in_valid), .sum(d1_sum), .cout(d1_cout),
`ifdef FACS_OVERFLOW_EN
    .ovf(d1_ovf),
`endif
    .out_valid(d1_ov)
  );

  facs #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .x(x8), .y(y8), .cin(cin),
    .in_valid(in_valid), .sum(d8_sum), .cout(d8_cout),
`ifdef FACS_OVERFLOW_EN
    .ovf(d8_ovf),
`endif
    .out_valid(d8_ov)
  );

  // Reference model: plain integer arithmetic on the effective operand.
  logic [7:0] yy;
  logic [8:0] f8;
  logic [1:0] f1;
  always_comb begin
    yy = mode ? ~y8 : y8;
    f8 = 9'(x8) + 9'(yy) + 9'(cin);
    f1 = 2'(x8[0]) + 2'(yy[0]) + 2'(cin);
  end

  logic       m1_sum, m1_cout, m_ov;
  logic [7:0] m8_sum;
  logic       m8_cout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1_sum <= 1'b0; m1_cout <= 1'b0; m8_sum <= 8'h00; m8_cout <= 1'b0; m_ov <= 1'b0;
`ifdef FACS_OVERFLOW_EN
      m1_ovf <= 1'b0; m8_ovf <= 1'b0;
`endif
    end else begin
      m_ov <= in_valid;
      if (in_valid) begin
        m1_sum  <= f1[0];
        m1_cout <= f1[1];
        m8_sum  <= f8[7:0];
        m8_cout <= f8[8];
`ifdef FACS_OVERFLOW_EN
        m1_ovf  <= (x8[0] == yy[0]) && (f1[0] != x8[0]);
        m8_ovf  <= (x8[7] == yy[7]) && (f8[7] != x8[7]);
`endif
      end
    end
  end

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the capturing edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("u1.sum", 9'(d1_sum), 9'(m1_sum));
      check("u1.cout", 9'(d1_cout), 9'(m1_cout));
      check("u1.out_valid", 9'(d1_ov), 9'(m_ov));
      check("u8.sum", 9'(d8_sum), 9'(m8_sum));
      check("u8.cout", 9'(d8_cout), 9'(m8_cout));
      check("u8.out_valid", 9'(d8_ov), 9'(m_ov));
`ifdef FACS_OVERFLOW_EN
      check("u1.ovf", 9'(d1_ovf), 9'(m1_ovf));
      check("u8.ovf", 9'(d8_ovf), 9'(m8_ovf));
`endif
    end
  end

  task automatic drive(input logic v, input logic m, input logic [7:0] xv,
                       input logic [7:0] yv, input logic ci);
    in_valid = v; mode = m; x8 = xv; y8 = yv; cin = ci;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {sum, cout} for index {mode, x, y, cin} at WIDTH=1.
  logic [1:0] tbl [16] = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11,
                           2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b01};

  typedef struct {
    logic       m;
    logic [7:0] xv;
    logic [7:0] yv;
    logic       ci;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec8_t;

  vec8_t v8 [11] = '{
    '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
    '{1'b1, 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0},
    '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
    '{1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{1'b0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0},
    '{1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0},
    '{1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0},
    '{1'b0, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0},
    '{1'b1, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0},
    '{1'b1, 8'hA5, 8'h5A, 1'b0, 8'h4A, 1'b1, 1'b1},
    '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1}
  };

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 8'h00, 8'h00, 0);
    repeat (2) step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    drive(1, 0, 8'h01, 8'h01, 1);
    step();
    check("first.u1.sum", 9'(d1_sum), 9'd1);
    check("first.u1.cout", 9'(d1_cout), 9'd1);
    check("first.u8.sum", 9'(d8_sum), 9'h003);

    // Asynchronous reset between edges with a valid vector pending.
    #2 rst_n = 1'b0;
    #1;
    check("rst.u1.sum", 9'(d1_sum), 9'd0);
    check("rst.u1.cout", 9'(d1_cout), 9'd0);
    check("rst.u1.out_valid", 9'(d1_ov), 9'd0);
    check("rst.u8.sum", 9'(d8_sum), 9'd0);
    step();
    check("rst_hold.u8.sum", 9'(d8_sum), 9'd0);
    rst_n = 1'b1;
    step();
    check("release.u1.sum", 9'(d1_sum), 9'd1);
    check("release.u1.cout", 9'(d1_cout), 9'd1);

    for (int i = 0; i < 16; i++) begin
      logic [3:0] b;
      b = 4'(i);
      drive(1, b[3], {7'b0, b[2]}, {7'b0, b[1]}, b[0]);
      step();
      check($sformatf("tbl%0d.sum", i), 9'(d1_sum), 9'(tbl[i][1]));
      check($sformatf("tbl%0d.cout", i), 9'(d1_cout), 9'(tbl[i][0]));
    end

    for (int i = 0; i < 3; i++) begin
      drive(0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      step();
      check("hold.u1.sum", 9'(d1_sum), 9'd0);
      check("hold.u1.cout", 9'(d1_cout), 9'd1);
      check("hold.out_valid", 9'(d1_ov), 9'd0);
      check("hold.u8.sum", 9'(d8_sum), 9'h000);
      check("hold.u8.cout", 9'(d8_cout), 9'd1);
    end

    for (int i = 0; i < 11; i++) begin
      drive(1, v8[i].m, v8[i].xv, v8[i].yv, v8[i].ci);
      step();
      check($sformatf("w8_%0d.sum", i), 9'(d8_sum), 9'(v8[i].es));
      check($sformatf("w8_%0d.cout", i), 9'(d8_cout), 9'(v8[i].ec));
`ifdef FACS_OVERFLOW_EN
      check($sformatf("w8_%0d.ovf", i), 9'(d8_ovf), 9'(v8[i].eo));
`endif
    end

    drive(0, 0, 8'h00, 8'h00, 0);
    repeat (2) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
